// File: rtl/cpu_axi_pkg.sv
// Definitions shared by the instruction cache and its AXI refill engine:
// read-channel encodings, the refill FSM state type and the default line size.
package cpu_axi_pkg;

  localparam int unsigned DEFAULT_LINE_WORDS = 8;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    DONE = 2'd3
  } refill_state_t;

endpackage

// File: rtl/icache_axi_refill.sv
// Instruction-cache line refill engine: one INCR burst per miss on the AXI read
// channels, beats gathered into a line buffer that is held until the next refill.
module icache_axi_refill
  import cpu_axi_pkg::*;
#(
  parameter int unsigned         LINE_WORDS = DEFAULT_LINE_WORDS,
  parameter int unsigned         ID_WIDTH   = 4,
  parameter logic [ID_WIDTH-1:0] AXI_ID     = {ID_WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_read_req,
  input  logic [31:0]                  mem_addr,
  output logic                         mem_gnt,
  output logic [LINE_WORDS-1:0][31:0]  ins,
  output logic                         rd_err,
  output logic [ID_WIDTH-1:0]          arid,
  output logic [31:0]                  araddr,
  output logic [7:0]                   arlen,
  output logic [2:0]                   arsize,
  output logic [1:0]                   arburst,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [ID_WIDTH-1:0]          rid,
  input  logic [31:0]                  rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready
);

  localparam int unsigned       BEAT_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [31:0]       LINE_MASK = 32'(LINE_WORDS * 4 - 1);

  refill_state_t               state_q;
  logic                        arvalid_q;
  logic                        rready_q;
  logic                        mem_gnt_q;
  logic                        rd_err_q;
  logic [31:0]                 araddr_q;
  logic [LINE_WORDS-1:0][31:0] ins_q;
  logic [BEAT_W-1:0]           beat_q;
  logic [BEAT_W-1:0]           beat_d;
  logic                        beat_err_s;
  logic                        unused_rid_s;

  assign beat_d = beat_q + BEAT_W'(1);

  // A beat is bad if the slave flags an error or RLAST disagrees with our beat count.
  assign beat_err_s = (rresp != RESP_OKAY) || (rlast != (beat_q == LAST_BEAT));

  // Only one burst is ever outstanding, so RID carries no information.
  assign unused_rid_s = ^rid;

  // Refill sequencer: request latch, AR handshake, beat capture and grant pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      mem_gnt_q <= 1'b0;
      rd_err_q  <= 1'b0;
      araddr_q  <= 32'h0000_0000;
      ins_q     <= '0;
      beat_q    <= {BEAT_W{1'b0}};
    end else begin
      mem_gnt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_read_req) begin
            state_q   <= AR;
            arvalid_q <= 1'b1;
            araddr_q  <= mem_addr & ~LINE_MASK;
            beat_q    <= {BEAT_W{1'b0}};
          end
        end
        AR: begin
          if (arready) begin
            state_q   <= R;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        R: begin
          if (rvalid) begin
            ins_q[beat_q] <= rdata;
            beat_q        <= beat_d;
            if (beat_err_s) begin
              rd_err_q <= 1'b1;
            end
            // Only RLAST ends the burst; a missing one just lets the counter wrap.
            if (rlast) begin
              state_q   <= DONE;
              rready_q  <= 1'b0;
              mem_gnt_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_gnt = mem_gnt_q;
  assign ins     = ins_q;
  assign rd_err  = rd_err_q;
  assign arid    = AXI_ID;
  assign araddr  = araddr_q;
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

endmodule
